// File: rtl/tx_fifo_pacer_if.sv
// Bus bundle between the terminal byte source, tx_fifo_pacer and uart_tx.
// Byte-source side: i_byte / i_byte_v push bytes in; o_full, o_count and
// o_overflow report FIFO status.
// uart_tx side: o_byte / o_byte_v launch one byte; i_tx_active / i_tx_done
// report transmitter status.
// Modports:
//   slave  - the pacer itself
//   master - whatever drives the pacer (byte source plus uart_tx)
interface tx_fifo_pacer_if #(
  parameter int AW = 4
);
  logic [7:0]  i_byte;
  logic        i_byte_v;
  logic        o_full;
  logic [AW:0] o_count;
  logic        o_overflow;
  logic [7:0]  o_byte;
  logic        o_byte_v;
  logic        i_tx_active;
  logic        i_tx_done;

  modport slave (
    input  i_byte, i_byte_v, i_tx_active, i_tx_done,
    output o_full, o_count, o_overflow, o_byte, o_byte_v
  );

  modport master (
    output i_byte, i_byte_v, i_tx_active, i_tx_done,
    input  o_full, o_count, o_overflow, o_byte, o_byte_v
  );
endinterface

// File: rtl/tx_fifo_pacer.sv
// Byte FIFO plus pacing FSM in front of uart_tx. Absorbs bursts that arrive
// faster than the line rate and hands uart_tx one byte at a time, each with
// a single-cycle o_byte_v strobe, only after the previous frame completed.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - tx_fifo_pacer_if.slave: push side (i_byte, i_byte_v, o_full,
//          o_count, o_overflow) and uart_tx side (o_byte, o_byte_v,
//          i_tx_active, i_tx_done)
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// SEND  | o_byte_v high for this one cycle
// WAIT  | frame in flight, waiting for i_tx_done
module tx_fifo_pacer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  tx_fifo_pacer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [7:0]    mem [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic          full_q,     full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    byte_q,     byte_d;
  logic          byte_v_q,   byte_v_d;

  logic          pop;
  logic          push_ok;

  // A launch is the only pop. It uses the registered count, so a byte pushed
  // at edge N is first visible to the FSM in the cycle after edge N.
  assign pop     = (state_q == IDLE) && (count_q != '0) && !bus.i_tx_active;
  // At full, a push is still taken when the same edge frees a slot.
  assign push_ok = bus.i_byte_v && (!full_q || pop);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    byte_d     = byte_q;
    byte_v_d   = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (bus.i_byte_v && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          byte_d   = mem[rd_ptr_q];
          byte_v_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    full_d = (count_d == CNT_DEPTH);
  end

  // Storage has no reset; the pointers alone define what is valid. When
  // full with a simultaneous pop, wr_ptr == rd_ptr: the head is read into
  // byte_q with the old contents at the same edge the new byte lands.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr_q] <= bus.i_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      byte_q     <= 8'h00;
      byte_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      byte_q     <= byte_d;
      byte_v_q   <= byte_v_d;
    end
  end

  assign bus.o_full     = full_q;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_byte     = byte_q;
  assign bus.o_byte_v   = byte_v_q;

endmodule
